keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad by driving columns and sampling rows, then debounces the result.
- Emits exactly one single-cycle strobe and a 4-bit key code per physical press.
- Sits directly upstream of the calculator's BCD digit register and operator register, and replaces their ad-hoc upcounter, decoder, debouncer and pulse chain.
- Runs entirely on the 50 MHz board clock, gated by an internal scan tick.

Parameters:
- SCAN_DIV, 100000: CLOCK_50 cycles per scan tick (500 Hz at 50 MHz); must be >= 2.
- DEBOUNCE_TICKS, 10: consecutive identical samples required to accept a press or a release; must be >= 1.
- REPEAT_DELAY, 250: ticks held before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_PERIOD, 50: ticks between auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous, active-low reset.
- ROW  in  4  keypad rows; active-low (pulled up), asynchronous to the clock.
- COL  out  4  column drive; one-hot active-low.
- key_code  out  4  code of the last accepted key; stable until the next accept.
- key_valid  out  1  one-cycle strobe; key_code is valid on this cycle.
- key_held  out  1  high from accept until the release is debounced.

Behaviour:
- Reset values:
  - COL = 4'b1110, key_code = 0, key_valid = 0, key_held = 0.
  - FSM = SCAN; tick prescaler and debounce counter = 0.
  - Reset mid-debounce or mid-hold aborts immediately; no strobe is generated.
- ROW passes through a 2-flop synchronizer (rs) before any use.
- Tick: prescaler counts 0..SCAN_DIV-1; tick = 1 for one cycle when the count wraps. All FSM decisions happen only on tick cycles.
- Key map, row r / column c. Codes are decimal, shown in brackets:
  - r0: 1, 2, 3, A [10]
  - r1: 4, 5, 6, B [11]
  - r2: 7, 8, 9, C [12]
  - r3: * [14], 0 [0], # [15], D [13]
  - Digits map to their own value. A/B/C/D are the add, subtract, multiply and clear operators.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - On tick, if rs has exactly one bit low: latch row index and current column, set cnt = 1, go to DEBOUNCE. COL is frozen.
  - Otherwise (including all-high and multi-row-low) rotate COL: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- DEBOUNCE:
  - On tick, if rs equals the latched pattern: cnt++.
  - When cnt reaches DEBOUNCE_TICKS: load key_code, pulse key_valid the next cycle, set key_held, go to HELD.
  - If rs mismatches on a tick: go to SCAN with COL unchanged. No strobe.
  - With DEBOUNCE_TICKS = 1, the capture tick itself accepts the key.
- HELD:
  - On tick, if rs = 4'b1111: cnt = 1, go to RELEASE.
  - A second key pressed while held is ignored.
- RELEASE:
  - On tick, if rs = 4'b1111: cnt++. Otherwise go back to HELD.
  - When cnt reaches DEBOUNCE_TICKS: clear key_held, go to SCAN, and resume rotating from the frozen column.
- Latency: key_valid rises 2 (sync) + up to SCAN_DIV*(DEBOUNCE_TICKS+4) cycles after a clean press.
- key_valid never asserts on two consecutive cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- When defined:
  - While in HELD, a repeat counter counts ticks.
  - After REPEAT_DELAY ticks it re-pulses key_valid with the same key_code, then re-pulses every REPEAT_PERIOD ticks.
  - Entering RELEASE clears the repeat counter.
- When undefined: exactly one strobe per press; the repeat logic and the REPEAT_* parameters are unused.

Decomposition:
- Shared package calc_pkg:
  - Key code constants KEY_ADD = 10, KEY_SUB = 11, KEY_MUL = 12, KEY_CLR = 13, KEY_STAR = 14, KEY_HASH = 15.
  - Scanner state enum (SCAN, DEBOUNCE, HELD, RELEASE).
  - The 16-entry row/col-to-code lookup function.
- One sub-module, scan_tick_gen: prescaler with parameter SCAN_DIV; outputs tick.

Test Plan (SCAN_DIV = 4, DEBOUNCE_TICKS = 3):
- Resetn low for 5 cycles, ROW = 1111 -> COL = 1110, key_valid = 0; COL then cycles through all four values every 16 cycles.
- Hold ROW = 1110 while COL = 1101 for 40 cycles -> exactly one key_valid with key_code = 2; key_held = 1 until 3 release ticks after ROW returns to 1111.
- ROW = 1011 on COL = 0111 (key C), glitch high after 1 tick -> no key_valid; FSM back in SCAN.
- ROW = 1010 (two rows low) held for 100 cycles -> no key_valid; COL keeps rotating.
- Resetn asserted while in DEBOUNCE at cnt = 2 -> outputs return to reset values immediately; no strobe after release of reset until a fresh full press.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY = 5, REPEAT_PERIOD = 2, key 0 held 60 cycles -> strobes at accept, +20 cycles, then every 8 cycles, all with key_code = 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scanner states and the
// row/column to key-code lookup used by keypad_scanner.
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_MUL  = 4'd12;
  localparam logic [3:0] KEY_CLR  = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Physical keypad layout: row 0 is the top row, column 0 the leftmost.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = KEY_ADD;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = KEY_SUB;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = KEY_MUL;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_CLR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan prescaler: counts 0..SCAN_DIV-1 and raises tick for the single cycle
// on which the count wraps.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner/debouncer: one key_valid strobe per accepted press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int REPEAT_DELAY   = 250,
  parameter int REPEAT_PERIOD  = 50
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] DB_CNT  = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("keypad_scanner: invalid parameter set");
  end

  // Index of the (lowest) low bit of an active-low one-hot vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  logic              tick;
  logic [3:0]        row_meta_reg, rs_reg;
  scan_state_t       state_reg, state_next;
  logic [3:0]        col_reg, col_next;
  logic [3:0]        pat_reg, pat_next;
  logic [1:0]        row_idx_reg, row_idx_next;
  logic [1:0]        col_idx_reg, col_idx_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic [3:0]        key_code_reg, key_code_next;
  logic              key_valid_reg, key_valid_next;
  logic              key_held_reg, key_held_next;
  logic              one_low;
  logic              accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_CNT  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_CNT = REP_W'(REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             rep_armed_reg, rep_armed_next;
`endif

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .tick  (tick)
  );

  assign one_low   = ($countones(~rs_reg) == 1);
  assign cnt_inc   = cnt_reg + 1'b1;
  assign COL       = col_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    pat_next       = pat_reg;
    row_idx_next   = row_idx_reg;
    col_idx_next   = col_idx_reg;
    cnt_next       = cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;
    accept         = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next   = rep_cnt_reg;
    rep_armed_next = rep_armed_reg;
`endif
    if (tick) begin
      unique case (state_reg)
        SCAN: begin
          if (one_low) begin
            pat_next     = rs_reg;
            row_idx_next = low_index(rs_reg);
            col_idx_next = low_index(col_reg);
            cnt_next     = CNT_ONE;
            if (CNT_ONE == DB_CNT) accept = 1'b1;
            else                   state_next = DEBOUNCE;
          end else begin
            col_next = {col_reg[2:0], col_reg[3]};
          end
        end
        DEBOUNCE: begin
          if (rs_reg == pat_reg) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_CNT) accept = 1'b1;
          end else begin
            state_next = SCAN;
          end
        end
        HELD: begin
          // Only a fully released keypad counts; extra keys are ignored.
          if (rs_reg == 4'hF) begin
            cnt_next = CNT_ONE;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_next   = '0;
            rep_armed_next = 1'b0;
`endif
            if (CNT_ONE == DB_CNT) begin
              key_held_next = 1'b0;
              state_next    = SCAN;
            end else begin
              state_next = RELEASE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
            if (rep_cnt_next == (rep_armed_reg ? REP_PERIOD_CNT : REP_DELAY_CNT)) begin
              rep_cnt_next   = '0;
              rep_armed_next = 1'b1;
              key_valid_next = 1'b1;
            end
          end
`endif
        end
        RELEASE: begin
          if (rs_reg == 4'hF) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_CNT) begin
              key_held_next = 1'b0;
              state_next    = SCAN;
            end
          end else begin
            state_next = HELD;
          end
        end
        default: state_next = SCAN;
      endcase
    end
    if (accept) begin
      state_next     = HELD;
      key_code_next  = key_lookup(row_idx_next, col_idx_next);
      key_valid_next = 1'b1;
      key_held_next  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_next   = '0;
      rep_armed_next = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      row_meta_reg  <= 4'hF;
      rs_reg        <= 4'hF;
      state_reg     <= SCAN;
      col_reg       <= 4'b1110;
      pat_reg       <= 4'hF;
      row_idx_reg   <= 2'd0;
      col_idx_reg   <= 2'd0;
      cnt_reg       <= '0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= '0;
      rep_armed_reg <= 1'b0;
`endif
    end else begin
      row_meta_reg  <= ROW;
      rs_reg        <= row_meta_reg;
      state_reg     <= state_next;
      col_reg       <= col_next;
      pat_reg       <= pat_next;
      row_idx_reg   <= row_idx_next;
      col_idx_reg   <= col_idx_next;
      cnt_reg       <= cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= rep_cnt_next;
      rep_armed_reg <= rep_armed_next;
`endif
    end
  end

endmodule
